// File: rtl/ddr3_ram_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_ram_arbiter
//   Shares the single ram_* request/response port of ddr3_core between two
//   pmem-style masters (in0, in1). Round-robin grant; a stalled request is
//   locked onto its port until the core accepts it; each port is limited to
//   MAX_OUTSTANDING accepted-but-unacked requests. The owning port is carried
//   in req_id[15] so responses can be routed back.
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   inN_wr_i/rd_i/req_id_i/addr_i/write_data_i   request from master N
//   inN_accept_o                    request of master N accepted this cycle
//   inN_ack_o/error_o               response valid / error for master N
//   inN_read_data_o/resp_id_o       response data / tag (broadcast)
//   out_wr_o/rd_o/req_id_o/addr_o/write_data_o   request to core
//   out_accept_i/ack_i/error_i/read_data_i/resp_id_i  from core
//   resp_err_o                      sticky: ack for a port with nothing open
// ---------------------------------------------------------------------------
module ddr3_ram_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [15:0]  in0_wr_i,
  input  logic         in0_rd_i,
  input  logic [15:0]  in0_req_id_i,
  input  logic [31:0]  in0_addr_i,
  input  logic [127:0] in0_write_data_i,
  output logic         in0_accept_o,
  output logic         in0_ack_o,
  output logic         in0_error_o,
  output logic [127:0] in0_read_data_o,
  output logic [15:0]  in0_resp_id_o,
  input  logic [15:0]  in1_wr_i,
  input  logic         in1_rd_i,
  input  logic [15:0]  in1_req_id_i,
  input  logic [31:0]  in1_addr_i,
  input  logic [127:0] in1_write_data_i,
  output logic         in1_accept_o,
  output logic         in1_ack_o,
  output logic         in1_error_o,
  output logic [127:0] in1_read_data_o,
  output logic [15:0]  in1_resp_id_o,
  output logic [15:0]  out_wr_o,
  output logic         out_rd_o,
  output logic [15:0]  out_req_id_o,
  output logic [31:0]  out_addr_o,
  output logic [127:0] out_write_data_o,
  input  logic         out_accept_i,
  input  logic         out_ack_i,
  input  logic         out_error_i,
  input  logic [127:0] out_read_data_i,
  input  logic [15:0]  out_resp_id_i,
  output logic         resp_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_gnt;
  logic          r_last;
  logic [CW-1:0] r_cnt0;
  logic [CW-1:0] r_cnt1;
  logic          r_resp_err;

  logic w_req0, w_req1, w_elig0, w_elig1;
  logic w_gnt, w_drive, w_accepted;
  logic w_ack0, w_ack1, w_inc0, w_inc1, w_dec0, w_dec1, w_spurious;
  logic w_unused_id;

  // Request id bit 15 of each master is replaced by the port number.
  assign w_unused_id = in0_req_id_i[15] ^ in1_req_id_i[15];

  assign w_req0  = (|in0_wr_i) | in0_rd_i;
  assign w_req1  = (|in1_wr_i) | in1_rd_i;
  assign w_elig0 = w_req0 & (r_cnt0 < MAX_C);
  assign w_elig1 = w_req1 & (r_cnt1 < MAX_C);

  // Grant selection and next lock state.
  always_comb begin
    w_gnt       = 1'b0;
    w_drive     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_LOCKED: begin
        // Held port wins; if it dropped its request nothing is driven.
        w_gnt   = r_gnt;
        w_drive = r_gnt ? w_req1 : w_req0;
      end
      ST_ARB: begin
        if (w_elig0 && w_elig1) begin
          w_gnt   = ~r_last;
          w_drive = 1'b1;
        end else if (w_elig0) begin
          w_gnt   = 1'b0;
          w_drive = 1'b1;
        end else if (w_elig1) begin
          w_gnt   = 1'b1;
          w_drive = 1'b1;
        end else begin
          w_gnt   = 1'b0;
          w_drive = 1'b0;
        end
      end
      default: begin
        w_gnt   = 1'b0;
        w_drive = 1'b0;
      end
    endcase
    if (w_drive && !out_accept_i) begin
      w_state_nxt = ST_LOCKED;
    end else begin
      w_state_nxt = ST_ARB;
    end
  end

  // Request mux towards the core.
  always_comb begin
    out_wr_o         = 16'h0000;
    out_rd_o         = 1'b0;
    out_req_id_o     = {1'b0, in0_req_id_i[14:0]};
    out_addr_o       = in0_addr_i;
    out_write_data_o = in0_write_data_i;
    if (w_gnt) begin
      out_req_id_o     = {1'b1, in1_req_id_i[14:0]};
      out_addr_o       = in1_addr_i;
      out_write_data_o = in1_write_data_i;
      if (w_drive) begin
        out_wr_o = in1_wr_i;
        out_rd_o = in1_rd_i;
      end else begin
        out_wr_o = 16'h0000;
        out_rd_o = 1'b0;
      end
    end else begin
      if (w_drive) begin
        out_wr_o = in0_wr_i;
        out_rd_o = in0_rd_i;
      end else begin
        out_wr_o = 16'h0000;
        out_rd_o = 1'b0;
      end
    end
  end

  assign w_accepted   = w_drive & out_accept_i;
  assign in0_accept_o = w_accepted & ~w_gnt;
  assign in1_accept_o = w_accepted &  w_gnt;

  // Response routing: bit 15 of the tag names the owning port.
  assign w_ack0          = out_ack_i & ~out_resp_id_i[15];
  assign w_ack1          = out_ack_i &  out_resp_id_i[15];
  assign in0_ack_o       = w_ack0;
  assign in1_ack_o       = w_ack1;
  assign in0_error_o     = w_ack0 & out_error_i;
  assign in1_error_o     = w_ack1 & out_error_i;
  assign in0_read_data_o = out_read_data_i;
  assign in1_read_data_o = out_read_data_i;
  assign in0_resp_id_o   = {1'b0, out_resp_id_i[14:0]};
  assign in1_resp_id_o   = {1'b0, out_resp_id_i[14:0]};

  // Acks against an empty counter are flagged and otherwise ignored.
  assign w_inc0     = w_accepted & ~w_gnt;
  assign w_inc1     = w_accepted &  w_gnt;
  assign w_dec0     = w_ack0 & (r_cnt0 != ZERO_C);
  assign w_dec1     = w_ack1 & (r_cnt1 != ZERO_C);
  assign w_spurious = (w_ack0 & (r_cnt0 == ZERO_C)) | (w_ack1 & (r_cnt1 == ZERO_C));

  // Lock / grant / round-robin state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_ARB;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_drive) begin
        r_gnt <= w_gnt;
      end else begin
        r_gnt <= r_gnt;
      end
      if (w_accepted) begin
        r_last <= w_gnt;
      end else begin
        r_last <= r_last;
      end
    end
  end

  // Outstanding counters; accept and ack in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt0 <= ZERO_C;
      r_cnt1 <= ZERO_C;
    end else begin
      case ({w_inc0, w_dec0})
        2'b10:   r_cnt0 <= r_cnt0 + ONE_C;
        2'b01:   r_cnt0 <= r_cnt0 - ONE_C;
        default: r_cnt0 <= r_cnt0;
      endcase
      case ({w_inc1, w_dec1})
        2'b10:   r_cnt1 <= r_cnt1 + ONE_C;
        2'b01:   r_cnt1 <= r_cnt1 - ONE_C;
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

  // Sticky unexpected-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_err <= 1'b0;
    end else if (w_spurious) begin
      r_resp_err <= 1'b1;
    end else begin
      r_resp_err <= r_resp_err;
    end
  end

  assign resp_err_o = r_resp_err;

endmodule

// File: tb/tb_ddr3_ram_arbiter.sv
// Directed bench for ddr3_ram_arbiter (MAX_OUTSTANDING = 2). Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_ddr3_ram_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  in0_wr, in1_wr;
  logic         in0_rd, in1_rd;
  logic [15:0]  in0_id, in1_id;
  logic [31:0]  in0_addr, in1_addr;
  logic [127:0] in0_wd, in1_wd;
  logic         in0_acc, in0_ack, in0_err, in1_acc, in1_ack, in1_err;
  logic [127:0] in0_rdata, in1_rdata;
  logic [15:0]  in0_rid, in1_rid;
  logic [15:0]  o_wr;
  logic         o_rd;
  logic [15:0]  o_id;
  logic [31:0]  o_addr;
  logic [127:0] o_wd;
  logic         c_acc, c_ack, c_err;
  logic [127:0] c_rdata;
  logic [15:0]  c_rid;
  logic         resp_err;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  ddr3_ram_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in0_wr_i(in0_wr), .in0_rd_i(in0_rd), .in0_req_id_i(in0_id),
    .in0_addr_i(in0_addr), .in0_write_data_i(in0_wd),
    .in0_accept_o(in0_acc), .in0_ack_o(in0_ack), .in0_error_o(in0_err),
    .in0_read_data_o(in0_rdata), .in0_resp_id_o(in0_rid),
    .in1_wr_i(in1_wr), .in1_rd_i(in1_rd), .in1_req_id_i(in1_id),
    .in1_addr_i(in1_addr), .in1_write_data_i(in1_wd),
    .in1_accept_o(in1_acc), .in1_ack_o(in1_ack), .in1_error_o(in1_err),
    .in1_read_data_o(in1_rdata), .in1_resp_id_o(in1_rid),
    .out_wr_o(o_wr), .out_rd_o(o_rd), .out_req_id_o(o_id),
    .out_addr_o(o_addr), .out_write_data_o(o_wd),
    .out_accept_i(c_acc), .out_ack_i(c_ack), .out_error_i(c_err),
    .out_read_data_i(c_rdata), .out_resp_id_i(c_rid),
    .resp_err_o(resp_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in0_wr = 16'h0; in0_rd = 1'b0; in0_id = 16'h0; in0_addr = 32'h0; in0_wd = 128'h0;
    in1_wr = 16'h0; in1_rd = 1'b0; in1_id = 16'h0; in1_addr = 32'h0; in1_wd = 128'h0;
    c_acc = 1'b0; c_ack = 1'b0; c_err = 1'b0; c_rdata = 128'h0; c_rid = 16'h0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_acc0", 128'(in0_acc), 128'(1'b0));
    chk("rst_acc1", 128'(in1_acc), 128'(1'b0));
    chk("rst_ack0", 128'(in0_ack), 128'(1'b0));
    chk("rst_ack1", 128'(in1_ack), 128'(1'b0));
    chk("rst_rd",   128'(o_rd),    128'(1'b0));
    chk("rst_wr",   128'(o_wr),    128'(16'h0));
    chk("rst_err",  128'(resp_err), 128'(1'b0));
    next();

    // 1: tie, port0 first then port1
    in0_rd = 1'b1; in0_id = 16'h0005; in1_rd = 1'b1; in1_id = 16'h0005; c_acc = 1'b1;
    @(negedge clk);
    chk("t1_c0_acc0", 128'(in0_acc), 128'(1'b1));
    chk("t1_c0_acc1", 128'(in1_acc), 128'(1'b0));
    chk("t1_c0_id",   128'(o_id),    128'(16'h0005));
    next();
    @(negedge clk);
    chk("t1_c1_acc0", 128'(in0_acc), 128'(1'b0));
    chk("t1_c1_acc1", 128'(in1_acc), 128'(1'b1));
    chk("t1_c1_id",   128'(o_id),    128'(16'h8005));
    next();

    // 2: lock on port1 while the core stalls
    do_reset();
    in1_wr = 16'hFFFF; in1_id = 16'h0002; in1_addr = 32'h0000_1000;
    in1_wd = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    @(negedge clk);
    chk("t2_c0_wr",   128'(o_wr),    128'(16'hFFFF));
    chk("t2_c0_addr", 128'(o_addr),  128'(32'h0000_1000));
    chk("t2_c0_acc1", 128'(in1_acc), 128'(1'b0));
    next();
    in0_rd = 1'b1; in0_id = 16'h0007; in0_addr = 32'h0000_2000;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t2_c%0d_addr", c), 128'(o_addr), 128'(32'h0000_1000));
      chk($sformatf("t2_c%0d_id", c),   128'(o_id),   128'(16'h8002));
      chk($sformatf("t2_c%0d_wd", c),   o_wd, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      chk($sformatf("t2_c%0d_acc0", c), 128'(in0_acc), 128'(1'b0));
      next();
    end
    c_acc = 1'b1;
    @(negedge clk);
    chk("t2_c3_acc1", 128'(in1_acc), 128'(1'b1));
    chk("t2_c3_acc0", 128'(in0_acc), 128'(1'b0));
    chk("t2_c3_addr", 128'(o_addr),  128'(32'h0000_1000));
    next();
    in1_wr = 16'h0;
    @(negedge clk);
    chk("t2_c4_acc0", 128'(in0_acc), 128'(1'b1));
    chk("t2_c4_addr", 128'(o_addr),  128'(32'h0000_2000));
    chk("t2_c4_id",   128'(o_id),    128'(16'h0007));
    next();

    // 3: outstanding limit of 2 on port0
    do_reset();
    in0_rd = 1'b1; in0_id = 16'h0001; c_acc = 1'b1;
    @(negedge clk);
    chk("t3_r1_acc0", 128'(in0_acc), 128'(1'b1));
    next();
    @(negedge clk);
    chk("t3_r2_acc0", 128'(in0_acc), 128'(1'b1));
    next();
    in1_rd = 1'b1; in1_id = 16'h0009;
    @(negedge clk);
    chk("t3_blk_acc0", 128'(in0_acc), 128'(1'b0));
    chk("t3_in1_acc1", 128'(in1_acc), 128'(1'b1));
    chk("t3_in1_id",   128'(o_id),    128'(16'h8009));
    next();
    in1_rd = 1'b0; c_ack = 1'b1; c_rid = 16'h0001;
    @(negedge clk);
    chk("t3_blk2_acc0", 128'(in0_acc), 128'(1'b0));
    chk("t3_blk2_rd",   128'(o_rd),    128'(1'b0));
    chk("t3_ack0",      128'(in0_ack), 128'(1'b1));
    next();
    c_ack = 1'b0;
    @(negedge clk);
    chk("t3_r3_acc0", 128'(in0_acc), 128'(1'b1));
    next();
    in0_rd = 1'b0;

    // 4: error response routed to port1 (one port1 request is open)
    c_ack = 1'b1; c_err = 1'b1; c_rid = 16'h8003; c_rdata = 128'hDEAD_BEEF;
    @(negedge clk);
    chk("t4_ack1",   128'(in1_ack),  128'(1'b1));
    chk("t4_err1",   128'(in1_err),  128'(1'b1));
    chk("t4_rid1",   128'(in1_rid),  128'(16'h0003));
    chk("t4_ack0",   128'(in0_ack),  128'(1'b0));
    chk("t4_rdata0", in0_rdata, 128'hDEAD_BEEF);
    next();
    idle();
    @(negedge clk);
    chk("t4_resp_err", 128'(resp_err), 128'(1'b0));
    next();

    // 5: ack with nothing outstanding
    do_reset();
    c_ack = 1'b1; c_rid = 16'h0000;
    next();
    c_ack = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 128'(resp_err), 128'(1'b1));
    next();
    next();
    @(negedge clk);
    chk("t5_err_sticky", 128'(resp_err), 128'(1'b1));
    next();
    // Counter stayed at 0: exactly two more reads fit
    in0_rd = 1'b1; c_acc = 1'b1;
    @(negedge clk);
    chk("t5_r1", 128'(in0_acc), 128'(1'b1));
    next();
    @(negedge clk);
    chk("t5_r2", 128'(in0_acc), 128'(1'b1));
    next();
    @(negedge clk);
    chk("t5_r3_blk", 128'(in0_acc), 128'(1'b0));
    next();

    // 6: async reset while locked on port1
    do_reset();
    c_ack = 1'b1; c_rid = 16'h8000;
    next();
    c_ack = 1'b0; in1_wr = 16'h00FF; in1_id = 16'h0004;
    next();
    in0_rd = 1'b1; in0_id = 16'h0006;
    @(negedge clk);
    chk("t6_locked_id", 128'(o_id),     128'(16'h8004));
    chk("t6_err_pre",   128'(resp_err), 128'(1'b1));
    next();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_err_clr", 128'(resp_err), 128'(1'b0));
    chk("t6_tie_id",  128'(o_id),     128'(16'h0006));
    @(negedge clk);
    rst_n = 1'b1;
    next();
    c_acc = 1'b1;
    @(negedge clk);
    chk("t6_acc0", 128'(in0_acc), 128'(1'b1));
    chk("t6_acc1", 128'(in1_acc), 128'(1'b0));
    next();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
